regfile_write_buffer: RTL

//   Write-side initiator for the 32x32 MIPS register file. Queues writeback requests in a small FIFO.

---
 rtl/regfile_write_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//   Write-side buffer in front of the 32x32 register file. Writeback requests
//   are queued in a small FIFO, and the head entry is drained onto the
//   regfile's synchronous write port on every clock edge while entries are
//   pending. Both read addresses are snooped so that consumers can bypass
//   data that has not been committed yet.
//
// Ports
//   Clk, Reset_n          clock (rising edge), asynchronous active-low reset
//   ReqValid/ReqReady     writeback request handshake
//   ReqAddr/ReqData       destination register and value of the request
//   RegWrite              regfile write enable (head entry present)
//   WriteRegister         regfile write address (head entry, else 0)
//   WriteData             regfile write data (head entry, else 0)
//   ReadRegister1/2       regfile read addresses being snooped
//   Hit1/Hit2             a pending entry matches the read address
//   HitData1/HitData2     newest pending data for the read address, else 0
//   Count                 number of valid entries
module regfile_write_buffer #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [AW-1:0]    ReqAddr,
  input  logic [WIDTH-1:0] ReqData,
  output logic             RegWrite,
  output logic [AW-1:0]    WriteRegister,
  output logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic             Hit1,
  output logic             Hit2,
  output logic [WIDTH-1:0] HitData1,
  output logic [WIDTH-1:0] HitData2,
  output logic [CW-1:0]    Count
);

  logic [AW-1:0]    addr_r [DEPTH];
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  logic accept_s;
  logic enq_s;
  logic pop_s;

  // Handshake and FIFO control decode.
  always_comb begin
    ReqReady = (count_r != CW'(DEPTH));
    accept_s = ReqValid && ReqReady;
    // Register 0 is hard-wired to zero, so such writes are swallowed.
    enq_s    = accept_s && (ReqAddr != AW'(0));
    pop_s    = (count_r != CW'(0));
  end

  // Pointer and occupancy state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; only the slot at the write pointer is updated.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_s && (wr_ptr_r == PW'(i))) begin
          addr_r[i] <= ReqAddr;
          data_r[i] <= ReqData;
        end else begin
          addr_r[i] <= addr_r[i];
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  // Write port driven straight from the head entry.
  always_comb begin
    Count = count_r;
    if (pop_s) begin
      RegWrite      = 1'b1;
      WriteRegister = addr_r[rd_ptr_r];
      WriteData     = data_r[rd_ptr_r];
    end else begin
      RegWrite      = 1'b0;
      WriteRegister = '0;
      WriteData     = '0;
    end
  end

  // Bypass search. Entries are walked oldest to newest starting at the
  // head, so a later match overrides an earlier one and the most recently
  // enqueued value wins. The head itself is included because its write is
  // only visible to regfile reads after this edge.
  always_comb begin
    Hit1     = 1'b0;
    Hit2     = 1'b0;
    HitData1 = '0;
    HitData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_r) && (ReadRegister1 != AW'(0)) &&
          (addr_r[rd_ptr_r + PW'(k)] == ReadRegister1)) begin
        Hit1     = 1'b1;
        HitData1 = data_r[rd_ptr_r + PW'(k)];
      end else begin
        Hit1     = Hit1;
        HitData1 = HitData1;
      end
      if ((CW'(k) < count_r) && (ReadRegister2 != AW'(0)) &&
          (addr_r[rd_ptr_r + PW'(k)] == ReadRegister2)) begin
        Hit2     = 1'b1;
        HitData2 = data_r[rd_ptr_r + PW'(k)];
      end else begin
        Hit2     = Hit2;
        HitData2 = HitData2;
      end
    end
  end

endmodule
